decode_stage: RTL and testbench

- Decode stage of the 3-stage RV32I core, directly upstream of the execution stage.
- Holds the 32x32 integer register file and decodes the fetched instruction.
- Reads rs1/rs2 with write-back bypass and registers inst/op1/op2 into the ID/EX pipeline register that feeds execution.
- Accepts the write-back (rd_data) of the instruction currently in EX.

---
 rtl/decode_stage.sv | 132 +++++++++++++
 tb/tb_decode_stage.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// RV32I decode stage: 32x32 register file, ADDI/ADD/SUB decode and the ID/EX pipeline register.
// Optional same-cycle write-back bypass on operand reads is enabled by defining DECODE_WB_BYPASS_EN.
module decode_stage #(
   parameter logic [31:0] NOP_INST            = 32'h0000_0013,
   parameter bit          CLEAR_REGS_ON_RESET = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] inst_i,
   input  logic        inst_valid_i,
   output logic        inst_ready_o,
   input  logic        stall_i,
   input  logic        flush_i,
   input  logic        wb_we_i,
   input  logic [4:0]  wb_addr_i,
   input  logic [31:0] wb_data_i,
   output logic [31:0] inst_o,
   output logic [31:0] op1_o,
   output logic [31:0] op2_o,
   output logic [4:0]  rd_addr_o,
   output logic        rd_we_o,
   output logic        ex_valid_o,
   output logic        illegal_o
);

   logic [31:0] rf [32];
   logic [31:0] rs1_val, rs2_val;
   logic [31:0] dec_inst, dec_op1, dec_op2;
   logic [4:0]  dec_rd;
   logic        dec_rd_we, dec_illegal;
   logic        is_addi, is_addsub;

   logic [31:0] inst_reg, op1_reg, op2_reg;
   logic [4:0]  rd_reg;
   logic        rd_we_reg, valid_reg, illegal_reg;

   // x0 is hard-wired; x1..x31 are individual registers so reset can clear them.
   assign rf[0] = '0;

   genvar gi;
   generate
      for (gi = 1; gi < 32; gi++) begin : g_reg
         logic [31:0] q_reg;
         if (CLEAR_REGS_ON_RESET) begin : g_clr
            always_ff @(posedge clk or posedge rst) begin
               if (rst)
                  q_reg <= '0;
               else if (wb_we_i && (wb_addr_i == 5'(gi)))
                  q_reg <= wb_data_i;
            end
         end else begin : g_keep
            always_ff @(posedge clk) begin
               if (wb_we_i && (wb_addr_i == 5'(gi)))
                  q_reg <= wb_data_i;
            end
         end
         assign rf[gi] = q_reg;
      end
   endgenerate

   always_comb begin
      rs1_val = rf[inst_i[19:15]];
      rs2_val = rf[inst_i[24:20]];
`ifdef DECODE_WB_BYPASS_EN
      if (wb_we_i && (wb_addr_i != 5'd0) && (wb_addr_i == inst_i[19:15]))
         rs1_val = wb_data_i;
      if (wb_we_i && (wb_addr_i != 5'd0) && (wb_addr_i == inst_i[24:20]))
         rs2_val = wb_data_i;
`endif
   end

   assign is_addi   = (inst_i[6:0] == 7'b0010011) && (inst_i[14:12] == 3'b000);
   assign is_addsub = (inst_i[6:0] == 7'b0110011) && (inst_i[14:12] == 3'b000) &&
                      ((inst_i[31:25] == 7'b0000000) || (inst_i[31:25] == 7'b0100000));

   // Rejected instructions travel as a bubble that still carries the illegal flag.
   always_comb begin
      dec_inst    = NOP_INST;
      dec_op1     = '0;
      dec_op2     = '0;
      dec_rd      = '0;
      dec_rd_we   = 1'b0;
      dec_illegal = 1'b1;
      if (is_addi || is_addsub) begin
         dec_inst    = inst_i;
         dec_op1     = rs1_val;
         dec_op2     = is_addi ? {{20{inst_i[31]}}, inst_i[31:20]} : rs2_val;
         dec_rd      = inst_i[11:7];
         dec_rd_we   = (inst_i[11:7] != 5'd0);
         dec_illegal = 1'b0;
      end
   end

   assign inst_ready_o = !stall_i;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inst_reg    <= NOP_INST;
         op1_reg     <= '0;
         op2_reg     <= '0;
         rd_reg      <= '0;
         rd_we_reg   <= 1'b0;
         valid_reg   <= 1'b0;
         illegal_reg <= 1'b0;
      end else if (flush_i || (!stall_i && !inst_valid_i)) begin
         inst_reg    <= NOP_INST;
         op1_reg     <= '0;
         op2_reg     <= '0;
         rd_reg      <= '0;
         rd_we_reg   <= 1'b0;
         valid_reg   <= 1'b0;
         illegal_reg <= 1'b0;
      end else if (!stall_i) begin
         inst_reg    <= dec_inst;
         op1_reg     <= dec_op1;
         op2_reg     <= dec_op2;
         rd_reg      <= dec_rd;
         rd_we_reg   <= dec_rd_we;
         valid_reg   <= 1'b1;
         illegal_reg <= dec_illegal;
      end
   end

   assign inst_o     = inst_reg;
   assign op1_o      = op1_reg;
   assign op2_o      = op2_reg;
   assign rd_addr_o  = rd_reg;
   assign rd_we_o    = rd_we_reg;
   assign ex_valid_o = valid_reg;
   assign illegal_o  = illegal_reg;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: scoreboard of expected ID/EX contents per clock.
// Expectations follow DECODE_WB_BYPASS_EN when it is defined for the build.
module tb_decode_stage;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] op1;
      logic [31:0] op2;
      logic [4:0]  rd;
      logic        rd_we;
      logic        valid;
      logic        illegal;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] inst_i;
   logic        inst_valid_i;
   logic        inst_ready_o;
   logic        stall_i;
   logic        flush_i;
   logic        wb_we_i;
   logic [4:0]  wb_addr_i;
   logic [31:0] wb_data_i;
   logic [31:0] inst_o, op1_o, op2_o;
   logic [4:0]  rd_addr_o;
   logic        rd_we_o, ex_valid_o, illegal_o;

   int          total = 0;
   int          bad   = 0;
   exp_t        sb [$];
   exp_t        last_exp;
   logic [31:0] model_rf [32];

   decode_stage dut (
      .clk(clk), .rst(rst),
      .inst_i(inst_i), .inst_valid_i(inst_valid_i), .inst_ready_o(inst_ready_o),
      .stall_i(stall_i), .flush_i(flush_i),
      .wb_we_i(wb_we_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i),
      .inst_o(inst_o), .op1_o(op1_o), .op2_o(op2_o),
      .rd_addr_o(rd_addr_o), .rd_we_o(rd_we_o),
      .ex_valid_o(ex_valid_o), .illegal_o(illegal_o)
   );

   always #5 clk = ~clk;

   function automatic exp_t bubble();
      exp_t e;
      e = '0;
      e.inst = 32'h0000_0013;
      return e;
   endfunction

   function automatic exp_t observe();
      exp_t o;
      o.inst = inst_o; o.op1 = op1_o; o.op2 = op2_o; o.rd = rd_addr_o;
      o.rd_we = rd_we_o; o.valid = ex_valid_o; o.illegal = illegal_o;
      return o;
   endfunction

   function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [4:0] rd);
      return {f7, rs2, rs1, 3'b000, rd, 7'b0110011};
   endfunction

   function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [4:0] rd);
      return {imm, rs1, 3'b000, rd, 7'b0010011};
   endfunction

   function automatic logic [31:0] read_model(input logic [4:0] idx, input logic we,
                                              input logic [4:0] wa, input logic [31:0] wd);
      logic [31:0] v;
      v = (idx == 5'd0) ? 32'd0 : model_rf[idx];
`ifdef DECODE_WB_BYPASS_EN
      if (we && wa != 5'd0 && wa == idx) v = wd;
`endif
      return v;
   endfunction

   function automatic exp_t decode_model(input logic [31:0] ins, input logic we,
                                         input logic [4:0] wa, input logic [31:0] wd);
      exp_t e;
      e = bubble();
      e.valid = 1'b1;
      if (ins[6:0] == 7'h13 && ins[14:12] == 3'd0) begin
         e.inst = ins;
         e.op1 = read_model(ins[19:15], we, wa, wd);
         e.op2 = {{20{ins[31]}}, ins[31:20]};
         e.rd = ins[11:7];
         e.rd_we = (ins[11:7] != 5'd0);
      end else if (ins[6:0] == 7'h33 && ins[14:12] == 3'd0 &&
                   (ins[31:25] == 7'h00 || ins[31:25] == 7'h20)) begin
         e.inst = ins;
         e.op1 = read_model(ins[19:15], we, wa, wd);
         e.op2 = read_model(ins[24:20], we, wa, wd);
         e.rd = ins[11:7];
         e.rd_we = (ins[11:7] != 5'd0);
      end else begin
         e.illegal = 1'b1;
      end
      return e;
   endfunction

   // Drive one clock of stimulus and queue the ID/EX contents it should produce.
   task automatic step(input logic [31:0] ins, input logic v, input logic st, input logic fl,
                       input logic we, input logic [4:0] wa, input logic [31:0] wd);
      exp_t e;
      inst_i = ins; inst_valid_i = v; stall_i = st; flush_i = fl;
      wb_we_i = we; wb_addr_i = wa; wb_data_i = wd;
      if (fl)      e = bubble();
      else if (st) e = last_exp;
      else if (v)  e = decode_model(ins, we, wa, wd);
      else         e = bubble();
      sb.push_back(e);
      last_exp = e;
      @(posedge clk);
      #1;
      if (we && wa != 5'd0) model_rf[wa] = wd;
   endtask

   task automatic test_reset();
      exp_t e, o;
      rst = 1'b1;
      inst_i = '0; inst_valid_i = 0; stall_i = 0; flush_i = 0;
      wb_we_i = 0; wb_addr_i = '0; wb_data_i = '0;
      for (int i = 0; i < 32; i++) model_rf[i] = '0;
      last_exp = bubble();
      @(posedge clk); #1;
      o = observe(); total++;
      if (o !== bubble()) begin bad++; $display("FAIL reset_state got=%h want=%h", o, bubble()); end
      else $display("txn reset_state ok");
      rst = 1'b0;
      // Fill x1..x31 so that the later reset visibly clears them.
      for (int i = 1; i < 32; i++) begin
         step(32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 5'(i), 32'hA500_0000 + 32'(i));
         e = sb.pop_front(); o = observe(); total++;
         if (o !== e) begin bad++; $display("FAIL fill_x%0d got=%h want=%h", i, o, e); end
      end
      step(i_type(12'h123, 5'd7, 5'd9), 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
      e = sb.pop_front(); o = observe(); total++;
      if (o !== e) begin bad++; $display("FAIL pre_reset_load got=%h want=%h", o, e); end
      else $display("txn pre_reset_load op1=%h", o.op1);
      // Asynchronous reset while stall, flush and a write-back are all active.
      #2 rst = 1'b1;
      #1;
      o = observe(); total++;
      if (o !== bubble()) begin bad++; $display("FAIL async_reset got=%h want=%h", o, bubble()); end
      else $display("txn async_reset ok");
      stall_i = 1; flush_i = 1; wb_we_i = 1; wb_addr_i = 5'd5; wb_data_i = 32'hFFFF_0000;
      inst_valid_i = 1;
      @(posedge clk); #1;
      o = observe(); total++;
      if (o !== bubble()) begin bad++; $display("FAIL reset_hold got=%h want=%h", o, bubble()); end
      rst = 1'b0;
      for (int i = 0; i < 32; i++) model_rf[i] = '0;
      last_exp = bubble();
      for (int i = 1; i < 32; i++) begin
         step(r_type(7'h00, 5'(i), 5'(i), 5'd1), 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
         e = sb.pop_front(); o = observe(); total++;
         if (o !== e || o.op1 !== 32'd0 || o.op2 !== 32'd0) begin
            bad++; $display("FAIL cleared_x%0d got=%h want=%h", i, o, e);
         end
      end
      $display("txn cleared_regs checked");
   endtask

   task automatic test_addi();
      exp_t e, o;
      step(32'hFFB0_0093, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
      e = sb.pop_front(); o = observe(); total++;
      if (o !== e || op2_o !== 32'hFFFF_FFFB || rd_addr_o !== 5'd1 || rd_we_o !== 1'b1 ||
          ex_valid_o !== 1'b1 || op1_o !== 32'd0) begin
         bad++; $display("FAIL addi got=%h want=%h", o, e);
      end else $display("txn addi op2=%h", op2_o);
      step(i_type(12'h7FF, 5'd0, 5'd0), 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
      e = sb.pop_front(); o = observe(); total++;
      if (o !== e || rd_we_o !== 1'b0) begin bad++; $display("FAIL addi_rd0 got=%h want=%h", o, e); end
      else $display("txn addi_rd0 rd_we=%b", rd_we_o);
   endtask

   task automatic test_bypass();
      exp_t e, o;
      logic [31:0] want;
`ifdef DECODE_WB_BYPASS_EN
      want = 32'd7;
`else
      want = 32'd5;
`endif
      step(32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd2, 32'd5);
      e = sb.pop_front(); o = observe(); total++;
      if (o !== e) begin bad++; $display("FAIL bypass_pre got=%h want=%h", o, e); end
      step(32'h0021_01B3, 1'b1, 1'b0, 1'b0, 1'b1, 5'd2, 32'd7);
      e = sb.pop_front(); o = observe(); total++;
      if (o !== e || op1_o !== want || op2_o !== want) begin
         bad++; $display("FAIL bypass got=%h want=%h", o, e);
      end else $display("txn bypass op1=%0d op2=%0d", op1_o, op2_o);
   endtask

   task automatic test_x0_write();
      exp_t e, o;
      step(32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 32'hDEAD_BEEF);
      e = sb.pop_front(); o = observe(); total++;
      if (o !== e) begin bad++; $display("FAIL x0_write got=%h want=%h", o, e); end
      step(32'h0000_0233, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 32'hDEAD_BEEF);
      e = sb.pop_front(); o = observe(); total++;
      if (o !== e || op1_o !== 32'd0 || op2_o !== 32'd0) begin
         bad++; $display("FAIL x0_read got=%h want=%h", o, e);
      end else $display("txn x0_read op1=%h op2=%h", op1_o, op2_o);
   endtask

   task automatic test_stall_flush();
      exp_t e, o;
      logic [31:0] nxt;
      nxt = r_type(7'h00, 5'd2, 5'd1, 5'd7);
      step(32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd1, 32'd100);
      void'(sb.pop_front());
      step(32'h4020_8333, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
      e = sb.pop_front(); o = observe(); total++;
      if (o !== e) begin bad++; $display("FAIL sub_load got=%h want=%h", o, e); end
      else $display("txn sub_load op1=%0d op2=%0d", op1_o, op2_o);
      for (int k = 0; k < 2; k++) begin
         inst_i = nxt; inst_valid_i = 1; stall_i = 1; flush_i = 0; wb_we_i = 0;
         #1; total++;
         if (inst_ready_o !== 1'b0) begin bad++; $display("FAIL ready_in_stall got=%b want=0", inst_ready_o); end
         step(nxt, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
         e = sb.pop_front(); o = observe(); total++;
         if (o !== e) begin bad++; $display("FAIL stall_hold%0d got=%h want=%h", k, o, e); end
         else $display("txn stall_hold%0d inst=%h", k, inst_o);
      end
      step(nxt, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0);
      e = sb.pop_front(); o = observe(); total++;
      if (o !== e || inst_o !== 32'h0000_0013 || ex_valid_o !== 1'b0) begin
         bad++; $display("FAIL flush_over_stall got=%h want=%h", o, e);
      end else $display("txn flush_over_stall inst=%h", inst_o);
      stall_i = 0; #1; total++;
      if (inst_ready_o !== 1'b1) begin bad++; $display("FAIL ready_free got=%b want=1", inst_ready_o); end
      step(nxt, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
      e = sb.pop_front(); o = observe(); total++;
      if (o !== e) begin bad++; $display("FAIL after_stall got=%h want=%h", o, e); end
      step(nxt, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
      e = sb.pop_front(); o = observe(); total++;
      if (o !== e) begin bad++; $display("FAIL no_input_bubble got=%h want=%h", o, e); end
      else $display("txn no_input_bubble ok");
   endtask

   task automatic test_illegal();
      exp_t e, o;
      step(32'h0000_2003, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
      e = sb.pop_front(); o = observe(); total++;
      if (o !== e || inst_o !== 32'h0000_0013 || rd_we_o !== 1'b0 || illegal_o !== 1'b1 ||
          ex_valid_o !== 1'b1) begin
         bad++; $display("FAIL illegal_lw got=%h want=%h", o, e);
      end else $display("txn illegal_lw ok");
      step(r_type(7'h01, 5'd1, 5'd1, 5'd3), 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
      e = sb.pop_front(); o = observe(); total++;
      if (o !== e || illegal_o !== 1'b1) begin bad++; $display("FAIL illegal_f7 got=%h want=%h", o, e); end
      else $display("txn illegal_f7 ok");
   endtask

   // Dependent chains with the bench acting as EX: last cycle's result is written back now.
   task automatic test_back_to_back();
      exp_t e, o;
      logic [31:0] ins, res;
      logic [4:0]  r1, r2, rd;
      logic        v, st, fl;
      for (int n = 0; n < 200; n++) begin
         r1 = 5'($urandom_range(0, 3));
         r2 = 5'($urandom_range(0, 3));
         rd = 5'($urandom_range(0, 3));
         case ($urandom_range(0, 4))
            0: ins = i_type(12'($urandom), r1, rd);
            1: ins = r_type(7'h00, r2, r1, rd);
            2: ins = r_type(7'h20, r2, r1, rd);
            3: ins = r_type(7'h01, r2, r1, rd);
            default: ins = $urandom;
         endcase
         v  = ($urandom_range(0, 3) != 0);
         st = ($urandom_range(0, 7) == 0);
         fl = ($urandom_range(0, 11) == 0);
         if (last_exp.inst[6:0] == 7'h33 && last_exp.inst[30])
            res = last_exp.op1 - last_exp.op2;
         else
            res = last_exp.op1 + last_exp.op2;
         step(ins, v, st, fl, last_exp.rd_we, last_exp.rd, res);
         e = sb.pop_front(); o = observe(); total++;
         if (o !== e) begin bad++; $display("FAIL chain%0d got=%h want=%h", n, o, e); end
         else $display("txn chain%0d inst=%h op1=%h op2=%h", n, inst_o, op1_o, op2_o);
      end
   endtask

   initial begin
      test_reset();
      test_addi();
      test_bypass();
      test_x0_write();
      test_stall_flush();
      test_illegal();
      test_back_to_back();
      total++;
      if (sb.size() != 0) begin bad++; $display("FAIL scoreboard_leftover got=%0d want=0", sb.size()); end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
